// File: rtl/reload_timer_arbiter.sv
// Shares one self-reloading up-counter among NUM_REQ requesters.
// Round-robin arbitration picks a requester and latches its start value.
// The counter then runs from that value up to all-ones.
// A one-cycle done pulse goes back to the granted requester.
module reload_timer_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_val_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       busy_o,
  output logic [WIDTH-1:0]           count_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e               state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [IDX_W-1:0]     gidx_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [WIDTH-1:0]     start_q;
  logic [WIDTH-1:0]     count_q;

  logic                 pick_found_c;
  logic [IDX_W-1:0]     pick_idx_c;
  logic [IDX_W-1:0]     scan_idx_c;
  logic [WIDTH-1:0]     pick_val_c;
  int unsigned          scan_c;

  // Round-robin scan starting at rr_ptr_q; first requester found wins.
  always_comb begin
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    scan_idx_c   = '0;
    scan_c       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_c = 32'(rr_ptr_q) + k;
      if (scan_c >= NUM_REQ) begin
        scan_c = scan_c - NUM_REQ;
      end
      scan_idx_c = IDX_W'(scan_c);
      if (!pick_found_c && req_i[scan_idx_c]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = scan_idx_c;
      end
    end
  end

  // Select the start value belonging to the chosen requester.
  always_comb begin
    pick_val_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx_c == IDX_W'(i)) begin
        pick_val_c = req_val_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // Job sequencer: arbitrate, load start value, count to MAX, signal done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      start_q  <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_found_c) begin
            gidx_q  <= pick_idx_c;
            gnt_q   <= NUM_REQ'(1) << pick_idx_c;
            start_q <= pick_val_c;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          count_q <= start_q;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (count_q == CNT_MAX) begin
            state_q <= S_DONE;
          end else begin
            count_q <= count_q + WIDTH'(1);
          end
        end
        S_DONE: begin
          rr_ptr_q <= (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
          gnt_q    <= '0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  // Outputs decode only from registered state and grant.
  assign gnt_o   = gnt_q;
  assign done_o  = (state_q == S_DONE) ? gnt_q : '0;
  assign busy_o  = (state_q != S_IDLE);
  assign count_o = count_q;

endmodule
